// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg -- shared definitions for the frame-buffer port arbiter.
//   AW_DEF / DW_DEF : default address / data widths (1024 x RGB565)
//   RGB_*           : RGB565 field positions inside a 16-bit pixel word
//   owner_e         : owner of the memory port in the previous cycle
//   rgb565()        : packs separate colour fields into one pixel word
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 16;

  localparam int RGB_R_HI = 15;
  localparam int RGB_R_LO = 11;
  localparam int RGB_G_HI = 10;
  localparam int RGB_G_LO = 5;
  localparam int RGB_B_HI = 4;
  localparam int RGB_B_LO = 0;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_SCAN = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  function automatic logic [15:0] rgb565(input logic [4:0] r,
                                         input logic [5:0] g,
                                         input logic [4:0] b);
    logic [15:0] px;
    px = '0;
    px[RGB_R_HI:RGB_R_LO] = r;
    px[RGB_G_HI:RGB_G_LO] = g;
    px[RGB_B_HI:RGB_B_LO] = b;
    return px;
  endfunction

endpackage

// File: rtl/fb_port_arbiter_wbuf.sv
// -----------------------------------------------------------------------------
// fb_wbuf_fifo -- 2-deep synchronous FIFO with valid/ready handshakes.
// Holds posted host writes ({addr, wdata}) when FB_ARB_WBUF_EN is defined.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : push handshake, in_data is the entry
//   out_valid/out_ready : pop handshake, out_data is the oldest entry
// in_ready deliberately ignores a same-cycle pop, keeping the full flag
// off the out_ready path.
// -----------------------------------------------------------------------------
module fb_wbuf_fifo #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] slot [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = slot[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // NOTE: storage is not reset; count gates out_valid, so stale slot contents
  // are never observed and the array can map onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push) slot[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// -----------------------------------------------------------------------------
// fb_port_arbiter -- shares one synchronous frame-buffer port between the
// scan-out reader (priority) and the host port. A starvation counter forces
// the host in after STARVE_MAX consecutive scan grants while it waits.
//   scan_req/scan_addr/scan_gnt/scan_rvalid/scan_rdata : scan reader side
//   host_valid/host_we/host_addr/host_wdata/host_ready
//   host_rvalid/host_rdata                             : host side
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata         : memory port
//                                                        (1-cycle read latency)
// Optional: define FB_ARB_WBUF_EN to add a 2-entry posted-write buffer on the
// host write path (instantiates fb_wbuf_fifo).
// -----------------------------------------------------------------------------
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scan_req,
  input  logic [AW-1:0] scan_addr,
  output logic          scan_gnt,
  output logic          scan_rvalid,
  output logic [DW-1:0] scan_rdata,
  input  logic          host_valid,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ready,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int            CW         = 4;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;
  owner_e        owner_q;
  owner_e        owner_d;
  logic          host_rd_q;

  // Host-side view of the memory port: who (if anyone) drives it this cycle.
  logic          host_pending;
  logic          force_host;
  logic          host_mem_gnt;
  logic          host_mem_we;
  logic [AW-1:0] host_mem_addr;
  logic [DW-1:0] host_mem_wdata;

`ifdef FB_ARB_WBUF_EN
  logic               wq_in_valid;
  logic               wq_in_ready;
  logic               wq_out_valid;
  logic [AW+DW-1:0]   wq_out_data;
  logic               host_rd_req;
  logic               drain;
  logic               rd_gnt;

  assign host_rd_req  = host_valid && !host_we;
  assign host_pending = wq_out_valid || host_rd_req;
  assign force_host   = host_pending && (starve_cnt == STARVE_LIM);
  // Buffered writes drain before any read, which keeps read-after-write order.
  assign drain        = wq_out_valid && (!scan_req || force_host);
  assign rd_gnt       = host_rd_req && !wq_out_valid && (!scan_req || force_host);
  assign wq_in_valid  = host_valid && host_we;
  assign host_ready   = (wq_in_valid && wq_in_ready) || rd_gnt;

  assign host_mem_gnt   = drain || rd_gnt;
  assign host_mem_we    = drain;
  assign host_mem_addr  = drain ? wq_out_data[AW+DW-1:DW] : host_addr;
  assign host_mem_wdata = wq_out_data[DW-1:0];

  fb_wbuf_fifo #(.W(AW + DW)) u_wbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (wq_in_valid),
    .in_ready  (wq_in_ready),
    .in_data   ({host_addr, host_wdata}),
    .out_valid (wq_out_valid),
    .out_ready (drain),
    .out_data  (wq_out_data)
  );
`else
  assign host_pending   = host_valid;
  assign force_host     = host_valid && (starve_cnt == STARVE_LIM);
  assign host_ready     = host_valid && (!scan_req || force_host);
  assign host_mem_gnt   = host_ready;
  assign host_mem_we    = host_we;
  assign host_mem_addr  = host_addr;
  assign host_mem_wdata = host_wdata;
`endif

  assign scan_gnt = scan_req && !force_host;

  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    mem_en    = scan_gnt || host_mem_gnt;
    mem_we    = host_mem_gnt && host_mem_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (scan_gnt) begin
      mem_addr = scan_addr;
    end else if (host_mem_gnt) begin
      mem_addr  = host_mem_addr;
      mem_wdata = host_mem_wdata;
    end
  end

  // Counts scan wins while the host has work queued; saturates at the limit,
  // where force_host takes over the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (host_mem_gnt || !host_pending) begin
      starve_cnt <= '0;
    end else if (scan_gnt && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Owner FSM: records which requester used the port last cycle, which is
  // exactly who the returning read data belongs to.
  always_comb begin
    owner_d = OWN_IDLE;
    if (scan_gnt)          owner_d = OWN_SCAN;
    else if (host_mem_gnt) owner_d = OWN_HOST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q   <= OWN_IDLE;
      host_rd_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      host_rd_q <= host_mem_gnt && !host_mem_we;
    end
  end

  assign scan_rvalid = (owner_q == OWN_SCAN);
  assign host_rvalid = (owner_q == OWN_HOST) && host_rd_q;
  assign scan_rdata  = mem_rdata;
  assign host_rdata  = mem_rdata;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_port_arbiter -- directed bench for fb_port_arbiter with a behavioural
// memory, a cycle-level reference model of the port sharing rules, and
// literal checks for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_fb_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scan_req = 1'b0;
  logic [AW-1:0] scan_addr = '0;
  logic          scan_gnt;
  logic          scan_rvalid;
  logic [DW-1:0] scan_rdata;
  logic          host_valid = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ready;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  fb_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_req    (scan_req),
    .scan_addr   (scan_addr),
    .scan_gnt    (scan_gnt),
    .scan_rvalid (scan_rvalid),
    .scan_rdata  (scan_rdata),
    .host_valid  (host_valid),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ready  (host_ready),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-buffer bank: synchronous single port, registered read data.
  logic [DW-1:0] bmem [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= bmem[mem_addr];
    end
  end

  logic [DW-1:0] pre [5] = '{16'h001f, 16'h000f, 16'h000e, 16'h0003, 16'h0001};
  localparam logic [DW-1:0] PIX65 = 16'h07e0;

  // ---------------------------------------------------------------------------
  // Reference model: the port goes to scan unless the host has already watched
  // SM scans go by; whoever does not take it leaves it to the other. Read data
  // comes from a shadow copy of the frame buffer one cycle later.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] shadow [1024];
  int            wait_cnt = 0;
  bit            e_srv = 1'b0;
  bit            e_hrv = 1'b0;
  logic [DW-1:0] e_sd = '0;
  logic [DW-1:0] e_hd = '0;
  bit            m_forced, m_scan, m_host;
  logic [AW-1:0] m_addr;

`ifndef FB_ARB_WBUF_EN
  always @(negedge clk) begin
    if (!rst_n) begin
      wait_cnt = 0;
      e_srv    = 1'b0;
      e_hrv    = 1'b0;
      check("m_rst_scan_rvalid", scan_rvalid, 0);
      check("m_rst_host_rvalid", host_rvalid, 0);
    end else begin
      check("m_scan_rvalid", scan_rvalid, e_srv);
      if (e_srv) check("m_scan_rdata", scan_rdata, e_sd);
      check("m_host_rvalid", host_rvalid, e_hrv);
      if (e_hrv) check("m_host_rdata", host_rdata, e_hd);
    end
    m_forced = rst_n && host_valid && (wait_cnt >= SM);
    m_scan   = scan_req && !m_forced;
    m_host   = host_valid && !m_scan;
    m_addr   = m_scan ? scan_addr : (m_host ? host_addr : '0);
    check("m_scan_gnt", scan_gnt, m_scan);
    check("m_host_ready", host_ready, m_host);
    check("m_one_grant", scan_gnt & host_ready, 0);
    check("m_mem_en", mem_en, m_scan | m_host);
    check("m_mem_we", mem_we, m_host & host_we);
    check("m_mem_addr", mem_addr, m_addr);
    if (m_host && host_we) check("m_mem_wdata", mem_wdata, host_wdata);
    if (rst_n) begin
      e_srv = m_scan;
      e_sd  = shadow[scan_addr];
      e_hrv = m_host && !host_we;
      e_hd  = shadow[host_addr];
      if (m_host && host_we) shadow[host_addr] = host_wdata;
      if (m_host || !host_valid) wait_cnt = 0;
      else if (m_scan)           wait_cnt = wait_cnt + 1;
    end
  end
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    scan_req   = 1'b0;
    scan_addr  = '0;
    host_valid = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
  endtask

  // Scan held high with a host read of 65 pending: expect exactly SM scan
  // grants, then one host grant with scan held off, then the read data.
  task automatic starve_round(input string tag);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    scan_req   = 1'b1;
    host_valid = 1'b1;
    host_we    = 1'b0;
    host_addr  = 10'd65;
    for (int c = 0; c < 20 && !got; c++) begin
      scan_addr = AW'(c);
      @(negedge clk);
      if (host_ready) begin
        got = 1'b1;
        check({tag, "_scan_grants"}, n, SM);
        check({tag, "_scan_held_off"}, scan_gnt, 0);
      end else if (scan_gnt) begin
        n++;
      end
      tick();
    end
    check({tag, "_host_granted"}, got, 1);
    host_valid = 1'b0;
    @(negedge clk);
    check({tag, "_host_rvalid"}, host_rvalid, 1);
    check({tag, "_host_rdata"}, host_rdata, PIX65);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  got;
    for (int i = 0; i < 1024; i++) begin
      bmem[i]   = '0;
      shadow[i] = '0;
    end
    for (int i = 0; i < 5; i++) begin
      bmem[i]   = pre[i];
      shadow[i] = pre[i];
    end
    bmem[65]   = PIX65;
    shadow[65] = PIX65;
    idle();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_scan_rvalid", scan_rvalid, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_grants", {scan_gnt, host_ready}, 0);
    tick();
    rst_n = 1'b1;
    tick();

`ifndef FB_ARB_WBUF_EN
    // Scan-only burst over addresses 0..4
    for (int i = 0; i < 5; i++) begin
      scan_req  = 1'b1;
      scan_addr = AW'(i);
      @(negedge clk);
      check("t1_scan_gnt", scan_gnt, 1);
      check("t1_host_rvalid", host_rvalid, 0);
      if (i > 0) begin
        check("t1_scan_rvalid", scan_rvalid, 1);
        check("t1_scan_rdata", scan_rdata, pre[i-1]);
      end
      tick();
    end
    idle();
    @(negedge clk);
    check("t1_last_rvalid", scan_rvalid, 1);
    check("t1_last_rdata", scan_rdata, pre[4]);
    tick();

    // Host write, then scan read-back of the same address
    host_valid = 1'b1;
    host_we    = 1'b1;
    host_addr  = 10'd64;
    host_wdata = 16'hf800;
    @(negedge clk);
    check("t2_host_ready", host_ready, 1);
    check("t2_mem_we", mem_we, 1);
    check("t2_mem_addr", mem_addr, 64);
    tick();
    idle();
    scan_req  = 1'b1;
    scan_addr = 10'd64;
    tick();
    idle();
    @(negedge clk);
    check("t2_readback_rvalid", scan_rvalid, 1);
    check("t2_readback_rdata", scan_rdata, 16'hf800);
    tick();

    // Starvation limit, twice in a row to show the count restarts
    starve_round("t3a");
    starve_round("t3b");
    idle();
    tick();

    // Alternating scan requests with a host read of 65
    got        = 1'b0;
    host_valid = 1'b1;
    host_we    = 1'b0;
    host_addr  = 10'd65;
    for (int c = 0; c < 10 && !got; c++) begin
      scan_req  = (c % 2 == 0);
      scan_addr = AW'(c);
      @(negedge clk);
      if (host_ready) begin
        got = 1'b1;
        check("t4_first_idle_cycle", c, 1);
        check("t4_scan_gnt", scan_gnt, 0);
      end
      tick();
    end
    check("t4_host_granted", got, 1);
    host_valid = 1'b0;
    scan_req   = 1'b1;
    @(negedge clk);
    check("t4_host_rvalid", host_rvalid, 1);
    check("t4_host_rdata", host_rdata, PIX65);
    tick();
    idle();
    tick();

    // Reset with starvation count part-way up and a scan read in flight
    scan_req   = 1'b1;
    host_valid = 1'b1;
    host_addr  = 10'd65;
    tick();
    tick();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    check("t5a_scan_rvalid_dropped", scan_rvalid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    starve_round("t5a_post");
    idle();
    tick();

    // Reset in the cycle after a host read grant
    host_valid = 1'b1;
    host_addr  = 10'd65;
    @(negedge clk);
    check("t5b_host_ready", host_ready, 1);
    tick();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    check("t5b_host_rvalid_dropped", host_rvalid, 0);
    check("t5b_mem_en", mem_en, 0);
    tick();
    rst_n = 1'b1;
    tick();
    host_valid = 1'b1;
    host_addr  = 10'd65;
    @(negedge clk);
    check("t5b_resume_ready", host_ready, 1);
    tick();
    idle();
    @(negedge clk);
    check("t5b_resume_rvalid", host_rvalid, 1);
    check("t5b_resume_rdata", host_rdata, PIX65);
    tick();
`else
    // Posted writes with scan held high
    scan_req   = 1'b1;
    scan_addr  = '0;
    host_valid = 1'b1;
    host_we    = 1'b1;
    host_addr  = 10'd100;
    host_wdata = 16'h1111;
    @(negedge clk);
    check("wb_w1_ready", host_ready, 1);
    tick();
    host_wdata = 16'h2222;
    @(negedge clk);
    check("wb_w2_ready", host_ready, 1);
    tick();
    host_addr  = 10'd101;
    host_wdata = 16'h3333;
    @(negedge clk);
    check("wb_w3_stalled", host_ready, 0);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      got = host_ready;
      tick();
    end
    check("wb_w3_accepted", got, 1);
    host_we   = 1'b0;
    host_addr = 10'd100;
    got = 1'b0;
    n   = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (host_ready) got = 1'b1;
      else            n++;
      tick();
    end
    check("wb_rd_granted", got, 1);
    check("wb_rd_withheld", n > 0, 1);
    host_valid = 1'b0;
    @(negedge clk);
    check("wb_rd_rvalid", host_rvalid, 1);
    check("wb_rd_rdata", host_rdata, 16'h2222);
    tick();
    idle();
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
